// File: rtl/conv_pkg.sv
// Shared convolution types: default pixel width and signed pixel type.
package conv_pkg;

    localparam int CONV_DATA_W = 8;

    typedef logic signed [CONV_DATA_W-1:0] pix_t;

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle between the pixel source, window generator and MAC.
interface conv_window_gen_if #(
    parameter int DATA_W = conv_pkg::CONV_DATA_W
);
    logic signed [DATA_W-1:0] pix_i;
    logic                     pix_valid_i;
    logic                     sof_i;
    logic signed [DATA_W-1:0] k_0, k_1, k_2, k_3, k_4, k_5, k_6, k_7, k_8;
    logic                     win_valid_o;
    logic                     frame_done_o;

    // pixel source side
    modport master (
        output pix_i, pix_valid_i, sof_i,
        input  k_0, k_1, k_2, k_3, k_4, k_5, k_6, k_7, k_8,
        input  win_valid_o, frame_done_o
    );

    // window generator side
    modport slave (
        input  pix_i, pix_valid_i, sof_i,
        output k_0, k_1, k_2, k_3, k_4, k_5, k_6, k_7, k_8,
        output win_valid_o, frame_done_o
    );
endinterface

// File: rtl/conv_line_buffer.sv
// One image line of storage, addressed by column; read returns the old
// contents in the same cycle the new pixel is written.
module conv_line_buffer #(
    parameter int DEPTH  = 416,
    parameter int DATA_W = 8
) (
    input  logic                      clk_i,
    input  logic                      en_i,
    input  logic [$clog2(DEPTH)-1:0]  addr_i,
    input  logic [DATA_W-1:0]         wr_data_i,
    output logic [DATA_W-1:0]         rd_data_o
);
    // contents are never cleared; the window valid logic masks stale lines
    logic [DATA_W-1:0] mem [DEPTH];

    assign rd_data_o = mem[addr_i];

    // write the incoming pixel over the slot just read
    always_ff @(posedge clk_i) begin
        if (en_i) mem[addr_i] <= wr_data_i;
    end
endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two line buffers feed a 3x3 shift window,
// valid only for windows fully inside the frame (no padding).
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = 416,
    parameter int IMG_H  = 416,
    parameter int DATA_W = CONV_DATA_W
) (
    input  logic             clk_i,
    input  logic             rst_n,
    conv_window_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic              accept;
    logic [CW-1:0]     col, eff_col;
    logic [RW-1:0]     row, eff_row;
    logic [DATA_W-1:0] lb0_q, lb1_q;
    logic              last_col, last_row, win_ok;

    // [row][col]; row 0 is the oldest line, col 0 the leftmost tap
    logic [2:0][2:0][DATA_W-1:0] win;
    logic                        win_valid_q, frame_done_q;

    assign accept = bus.pix_valid_i;

    // sof forces the accepted pixel to (0,0) whatever the counters hold
    always_comb begin
        eff_col = col;
        eff_row = row;
        if (bus.sof_i) begin
            eff_col = '0;
            eff_row = '0;
        end
    end

    assign last_col = (eff_col == CW'(IMG_W - 1));
    assign last_row = (eff_row == RW'(IMG_H - 1));
    assign win_ok   = (eff_row >= RW'(2)) && (eff_col >= CW'(2));

    // lb1 holds the previous line, lb0 the line before it
    conv_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
        .clk_i     (clk_i),
        .en_i      (accept),
        .addr_i    (eff_col),
        .wr_data_i (bus.pix_i),
        .rd_data_o (lb1_q)
    );

    conv_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb0 (
        .clk_i     (clk_i),
        .en_i      (accept),
        .addr_i    (eff_col),
        .wr_data_i (lb1_q),
        .rd_data_o (lb0_q)
    );

    // raster position of the next pixel; wraps at frame end so frames chain
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : eff_row + RW'(1);
            end else begin
                col <= eff_col + CW'(1);
                row <= eff_row;
            end
        end
    end

    // shift window left, new column {lb0, lb1, pix} enters on the right
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            win <= '0;
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb0_q;
            win[1][2] <= lb1_q;
            win[2][2] <= bus.pix_i;
        end
    end

    // strobes last exactly one cycle after the qualifying pixel
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            win_valid_q  <= accept && win_ok;
            frame_done_q <= accept && last_col && last_row;
        end
    end

    assign bus.k_0 = win[0][0];
    assign bus.k_1 = win[0][1];
    assign bus.k_2 = win[0][2];
    assign bus.k_3 = win[1][0];
    assign bus.k_4 = win[1][1];
    assign bus.k_5 = win[1][2];
    assign bus.k_6 = win[2][0];
    assign bus.k_7 = win[2][1];
    assign bus.k_8 = win[2][2];

    assign bus.win_valid_o  = win_valid_q;
    assign bus.frame_done_o = frame_done_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized bench for conv_window_gen against an image-array reference model.
module tb_conv_window_gen;
    import conv_pkg::*;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int DW = 8;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_i = ~clk_i;

    conv_window_gen_if #(.DATA_W(DW)) bus ();

    conv_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;

    // reference model: the frame as an image, plus its raster position
    int mr, mc;
    int img [H][W];
    int ek [9];
    int ev, ed;
    bit taps_known;

    // observation bookkeeping
    int obs_win, obs_done, pix_idx, first_idx;
    int fw [9];
    int lw [9];
    int first_ref [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    int last_ref  [9] = '{7, 8, 9, 12, 13, 14, 17, 18, 19};

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic int tap(input int i);
        case (i)
            0: return int'(bus.k_0);
            1: return int'(bus.k_1);
            2: return int'(bus.k_2);
            3: return int'(bus.k_3);
            4: return int'(bus.k_4);
            5: return int'(bus.k_5);
            6: return int'(bus.k_6);
            7: return int'(bus.k_7);
            default: return int'(bus.k_8);
        endcase
    endfunction

    task automatic model_reset();
        mr = 0;
        mc = 0;
        for (int i = 0; i < 9; i++) ek[i] = 0;
        taps_known = 1'b1;
    endtask

    task automatic clear_obs();
        obs_win   = 0;
        obs_done  = 0;
        pix_idx   = 0;
        first_idx = -1;
    endtask

    // one clock: drive at negedge, update model, check just after posedge
    task automatic step(input bit v, input int p, input bit s);
        @(negedge clk_i);
        bus.pix_valid_i = v;
        bus.pix_i       = DW'(p);
        bus.sof_i       = s;
        ev = 0;
        ed = 0;
        if (v) begin
            pix_idx++;
            if (s) begin
                mr = 0;
                mc = 0;
            end
            img[mr][mc] = p;
            if (mr >= 2 && mc >= 2) begin
                ev = 1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ek[3*i+j] = img[mr-2+i][mc-2+j];
                taps_known = 1'b1;
            end else begin
                taps_known = 1'b0;
            end
            ed = (mr == H-1 && mc == W-1) ? 1 : 0;
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H-1) ? 0 : mr + 1;
            end
        end
        @(posedge clk_i);
        #1;
        chk("win_valid", int'(bus.win_valid_o), ev);
        chk("frame_done", int'(bus.frame_done_o), ed);
        if (taps_known)
            for (int i = 0; i < 9; i++) chk($sformatf("k_%0d", i), tap(i), ek[i]);
        if (bus.win_valid_o) begin
            for (int i = 0; i < 9; i++) begin
                if (obs_win == 0) fw[i] = tap(i);
                lw[i] = tap(i);
            end
            if (first_idx < 0) first_idx = pix_idx;
            obs_win++;
        end
        if (bus.frame_done_o) obs_done++;
    endtask

    task automatic pix_p(input int k, output int p);
        p = k;
    endtask

    // one frame in raster order; optional gaps, random pixels, sof on first pixel
    task automatic run_frame(input int gapmax, input bit rnd, input bit sof_first);
        int p;
        pix_idx = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (gapmax > 0) begin
                    int g = $urandom_range(0, gapmax);
                    for (int k = 0; k < g; k++) step(1'b0, $urandom_range(0, 255), 1'b1);
                end
                if (rnd) p = $urandom_range(0, 255) - 128;
                else     pix_p(r*W + c, p);
                step(1'b1, p, sof_first && r == 0 && c == 0);
            end
    endtask

    task automatic check_frame(input string tag, input int nwin, input int ndone, input bit vals);
        chk({tag, "_win_cnt"}, obs_win, nwin);
        chk({tag, "_done_cnt"}, obs_done, ndone);
        chk({tag, "_first_idx"}, first_idx, 13);
        if (vals)
            for (int i = 0; i < 9; i++) begin
                chk($sformatf("%s_first_k%0d", tag, i), fw[i], first_ref[i]);
                chk($sformatf("%s_last_k%0d", tag, i), lw[i], last_ref[i]);
            end
    endtask

    initial begin
        bus.pix_i       = '0;
        bus.pix_valid_i = 1'b0;
        bus.sof_i       = 1'b0;
        model_reset();
        clear_obs();
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_win_valid", int'(bus.win_valid_o), 0);
        chk("rst_frame_done", int'(bus.frame_done_o), 0);
        for (int i = 0; i < 9; i++) chk($sformatf("rst_k%0d", i), tap(i), 0);
        @(negedge clk_i);
        rst_n = 1'b1;

        // continuous single frame
        clear_obs();
        run_frame(0, 1'b0, 1'b0);
        check_frame("cont", 6, 1, 1'b1);

        // random gaps, sof asserted during gaps must be ignored
        clear_obs();
        run_frame(4, 1'b0, 1'b0);
        check_frame("gaps", 6, 1, 1'b1);

        // two back-to-back frames, no sof
        clear_obs();
        run_frame(0, 1'b0, 1'b0);
        check_frame("b2b_f1", 6, 1, 1'b1);
        run_frame(0, 1'b0, 1'b0);
        chk("b2b_win_total", obs_win, 12);
        chk("b2b_done_total", obs_done, 2);
        for (int i = 0; i < 9; i++) chk($sformatf("b2b_f2_last_k%0d", i), lw[i], last_ref[i]);

        // partial frame of 7 pixels, then restart with sof on the 8th
        clear_obs();
        for (int k = 0; k < 7; k++) step(1'b1, 100 + k, 1'b0);
        run_frame(0, 1'b0, 1'b1);
        check_frame("sof", 6, 1, 1'b1);

        // async reset after 9 pixels, then a full frame without sof
        clear_obs();
        for (int k = 0; k < 9; k++) step(1'b1, k, 1'b0);
        @(negedge clk_i);
        bus.pix_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_win_valid", int'(bus.win_valid_o), 0);
        chk("arst_frame_done", int'(bus.frame_done_o), 0);
        for (int i = 0; i < 9; i++) chk($sformatf("arst_k%0d", i), tap(i), 0);
        model_reset();
        @(negedge clk_i);
        rst_n = 1'b1;
        clear_obs();
        run_frame(0, 1'b0, 1'b0);
        check_frame("post_rst", 6, 1, 1'b1);

        // random signed pixels with random gaps
        for (int f = 0; f < 3; f++) begin
            clear_obs();
            run_frame(3, 1'b1, 1'b0);
            check_frame($sformatf("rnd%0d", f), 6, 1, 1'b0);
        end

        step(1'b0, 0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
